axi_mst_read: RTL

AXI_MST_READ -- requirements
Module: axi_mst_read

---
 rtl/axi_mst_pkg.sv | 38 +++
 rtl/fifo_axi.sv | 56 +++++
 rtl/synchronizer_n.sv | 29 ++
 rtl/axi_mst_read.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/axi_mst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_mst_pkg
// Description : Shared types and helpers for the AXI read/write masters.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_mst_pkg;

    typedef enum logic [3:0] {
        INIT_ST        = 4'd0,
        TRIGGER_ST     = 4'd1,
        READ_REGS_ST   = 4'd2,
        INIT_ADDR_ST   = 4'd3,
        INCR_ADDR_ST   = 4'd4,
        ADDR_ST        = 4'd5,
        DATA_ST        = 4'd6,
        NBURST_ST      = 4'd7,
        TRIGGER_END_ST = 4'd8,
        END_ST         = 4'd9
    } state_t;

    localparam logic [1:0] c_resp_okay  = 2'b00;
    localparam logic [1:0] c_burst_incr = 2'b01;

    // Bytes per beat to AxSIZE encoding; non power-of-two widths map to 0.
    function automatic logic [2:0] bytes_to_axsize(input int unsigned nbytes);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (nbytes == (32'd1 << i)) begin
                size = i[2:0];
            end
        end
        return size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_axi.sv
`default_nettype none
// ============================================================================
// Module      : fifo_axi
// Description : Synchronous first-word-fall-through FIFO, power-of-two depth.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_axi #(
    parameter int WIDTH      = 65,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int c_depth = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    r_mem [c_depth];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                w_push;
    logic                w_pop;

    assign w_push = wr_en & ~full;
    assign w_pop  = rd_en & ~empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                   (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    assign rd_data = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

endmodule
`default_nettype wire

// File: rtl/synchronizer_n.sv
`default_nettype none
// ============================================================================
// Module      : synchronizer_n
// Description : N-flop single-bit synchronizer with synchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module synchronizer_n #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/axi_mst_read.sv
`default_nettype none
// ============================================================================
// Module      : axi_mst_read
// Description : Triggered AXI4 burst read master streaming data out on AXIS.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mst_read
    import axi_mst_pkg::*;
#(
    parameter int ID_WIDTH     = 1,
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_LENGTH = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trigger,
    input  logic                    START_REG,
    input  logic [31:0]             ADDR_REG,
    input  logic [31:0]             NBURST_REG,
    output logic                    ERR_REG,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [31:0]             m_axi_araddr,
    output logic [3:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arregion,
    output logic [3:0]              m_axi_arqos,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                    m_axis_tlast
);

    localparam int          c_bytes       = DATA_WIDTH / 8;
    localparam logic [31:0] c_burst_bytes = 32'((BURST_LENGTH + 1) * c_bytes);
    localparam logic [3:0]  c_last_beat   = 4'(BURST_LENGTH);

    state_t              r_state;
    state_t              w_next;
    logic                w_rstn;
    logic                w_start;
    logic                w_trig;
    logic [31:0]         r_base;
    logic [31:0]         r_nburst;
    logic [31:0]         r_burst_cnt;
    logic [31:0]         r_araddr;
    logic [3:0]          r_beat_cnt;
    logic                r_err;
    logic                w_arvalid;
    logic                w_rready;
    logic                w_beat;
    logic                w_last_beat;
    logic                w_last_burst;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [DATA_WIDTH:0] w_fifo_rd;
    logic                w_unused_rid;

    assign w_rstn       = ~rst;
    assign w_unused_rid = ^m_axi_rid;

    synchronizer_n #(.STAGES(2)) u_sync_start (
        .clk  (clk),
        .rstn (w_rstn),
        .d    (START_REG),
        .q    (w_start)
    );

    synchronizer_n #(.STAGES(2)) u_sync_trig (
        .clk  (clk),
        .rstn (w_rstn),
        .d    (trigger),
        .q    (w_trig)
    );

    assign w_beat       = m_axi_rvalid & m_axi_rready;
    assign w_last_beat  = (r_beat_cnt == c_last_beat);
    assign w_last_burst = ((r_burst_cnt + 32'd1) == r_nburst);

    always_ff @(posedge clk) begin
        if (rst) r_state <= INIT_ST;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        case (r_state)
            INIT_ST:        if (w_start) w_next = TRIGGER_ST;
            TRIGGER_ST:     if (w_trig)  w_next = READ_REGS_ST;
            // NBURST_REG is sampled directly here since r_nburst loads on this same edge.
            READ_REGS_ST:   w_next = (NBURST_REG == 32'd0) ? TRIGGER_END_ST : INIT_ADDR_ST;
            INIT_ADDR_ST:   w_next = ADDR_ST;
            INCR_ADDR_ST:   w_next = ADDR_ST;
            ADDR_ST: begin
                w_arvalid = 1'b1;
                if (m_axi_arready) w_next = DATA_ST;
            end
            DATA_ST: begin
                w_rready = ~w_fifo_full;
                if (w_beat && w_last_beat) w_next = NBURST_ST;
            end
            NBURST_ST:      w_next = (r_burst_cnt == r_nburst) ? TRIGGER_END_ST : INCR_ADDR_ST;
            TRIGGER_END_ST: if (!w_trig)  w_next = END_ST;
            END_ST:         if (!w_start) w_next = INIT_ST;
            default:        w_next = INIT_ST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base      <= '0;
            r_nburst    <= '0;
            r_burst_cnt <= '0;
            r_araddr    <= '0;
            r_beat_cnt  <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                READ_REGS_ST: begin
                    r_base      <= ADDR_REG;
                    r_nburst    <= NBURST_REG;
                    r_burst_cnt <= '0;
                    r_err       <= 1'b0;
                end
                INIT_ADDR_ST: r_araddr   <= r_base;
                INCR_ADDR_ST: r_araddr   <= r_araddr + c_burst_bytes;
                ADDR_ST:      r_beat_cnt <= '0;
                DATA_ST: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                        if (w_last_beat) r_burst_cnt <= r_burst_cnt + 32'd1;
                        if ((m_axi_rresp != c_resp_okay) || (m_axi_rlast != w_last_beat)) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    fifo_axi #(
        .WIDTH      (DATA_WIDTH + 1),
        .DEPTH_LOG2 (4)
    ) u_fifo (
        .clk     (clk),
        .rstn    (w_rstn),
        .wr_en   (w_beat),
        .wr_data ({w_last_beat & w_last_burst, m_axi_rdata}),
        .rd_en   (m_axis_tvalid & m_axis_tready),
        .rd_data (w_fifo_rd),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign m_axis_tvalid  = ~w_fifo_empty;
    assign m_axis_tdata   = w_fifo_rd[DATA_WIDTH-1:0];
    assign m_axis_tlast   = w_fifo_rd[DATA_WIDTH] & ~w_fifo_empty;
    assign m_axis_tstrb   = '1;

    assign m_axi_arid     = '0;
    assign m_axi_araddr   = r_araddr;
    assign m_axi_arlen    = c_last_beat;
    assign m_axi_arsize   = bytes_to_axsize(c_bytes);
    assign m_axi_arburst  = c_burst_incr;
    assign m_axi_arlock   = 1'b0;
    assign m_axi_arcache  = 4'd0;
    assign m_axi_arprot   = 3'b010;
    assign m_axi_arregion = 4'd0;
    assign m_axi_arqos    = 4'd0;
    assign m_axi_arvalid  = w_arvalid;
    assign m_axi_rready   = w_rready;
    assign ERR_REG        = r_err;

endmodule
`default_nettype wire
